// File: rtl/sram_pkg.sv
// Shared definitions for the data-SRAM responder: FSM encoding, latency
// counter width and the byte-lane merge used for masked stores.
package sram_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int RESP_CNT_W = 4;

    // Replace the bytes of old_word selected by mask with the same lanes of new_word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                merged[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_array.sv
// 2**ADDR_W x 32 word storage with byte-enable write and a response data
// register that captures read data (or zero for writes) on each access.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_en,
    input  logic [3:0]        acc_we,
    input  logic [ADDR_W-1:0] acc_index,
    input  logic [31:0]       acc_wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [0:(2**ADDR_W)-1];
    logic [31:0] rdata_r;

    // Storage is intentionally not reset; only masked lanes change on a write.
    always_ff @(posedge clk) begin
        if (acc_en && (acc_we != 4'b0000)) begin
            mem_r[acc_index] <= byte_merge(mem_r[acc_index], acc_wdata, acc_we);
        end
    end

    // Response data: old word for reads, zero for writes; held between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (acc_en) begin
            rdata_r <= (acc_we != 4'b0000) ? 32'h0000_0000 : mem_r[acc_index];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data-SRAM port: one outstanding request,
// completion after LATENCY cycles on a valid/ready response channel.
module data_sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    input  logic        rsp_ready
);

    // A single-cycle latency skips WAIT so back-to-back accepts stay in RESP.
    localparam logic [RESP_CNT_W-1:0] LAT_M1    = RESP_CNT_W'(LATENCY - 1);
    localparam logic [1:0]            ACC_STATE = (LATENCY == 1) ? S_RESP : S_WAIT;
    localparam logic                  ACC_VALID = (LATENCY == 1) ? 1'b1 : 1'b0;

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [RESP_CNT_W-1:0] cnt_r;
    logic [RESP_CNT_W-1:0] cnt_nxt_s;
    logic                  rsp_valid_r;
    logic                  valid_nxt_s;
    logic                  req_ready_s;
    logic                  accept_s;
    logic [31:0]           rdata_s;
    logic                  unused_addr_s;

    assign unused_addr_s = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};

    assign req_ready_s = resetn &&
                         ((state_r == S_IDLE) || ((state_r == S_RESP) && rsp_ready));
    assign accept_s    = req_en && req_ready_s;

    // Next-state, countdown and response-valid logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        valid_nxt_s = rsp_valid_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACC_STATE;
                    cnt_nxt_s   = LAT_M1;
                    valid_nxt_s = ACC_VALID;
                end else begin
                    state_nxt_s = S_IDLE;
                    valid_nxt_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_r <= {{(RESP_CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nxt_s = S_RESP;
                    cnt_nxt_s   = {RESP_CNT_W{1'b0}};
                    valid_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - {{(RESP_CNT_W-1){1'b0}}, 1'b1};
                    valid_nxt_s = 1'b0;
                end
            end
            S_RESP: begin
                if (accept_s) begin
                    state_nxt_s = ACC_STATE;
                    cnt_nxt_s   = LAT_M1;
                    valid_nxt_s = ACC_VALID;
                end else if (rsp_ready) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = {RESP_CNT_W{1'b0}};
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = {RESP_CNT_W{1'b0}};
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and response-valid registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_IDLE;
            cnt_r       <= {RESP_CNT_W{1'b0}};
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rsp_valid_r <= valid_nxt_s;
        end
    end

    sram_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (resetn),
        .acc_en   (accept_s),
        .acc_we   (req_we),
        .acc_index(req_addr[ADDR_W+1:2]),
        .acc_wdata(req_wdata),
        .rdata    (rdata_s)
    );

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_s;

endmodule
